// File: rtl/day3_group_sequencer.sv
// Walks a byte-coded ROM of item lines in groups of three. For each group it
// adds the lowest priority common to all three lines to a running sum.
module day3_group_sequencer #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_PRIO = 52
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [31:0]       sum,
  output logic [15:0]       group_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned MASK_W = 64;
  localparam logic [7:0]  MAX_BYTE = 8'(MAX_PRIO);
  // Legal priorities occupy bits MAX_PRIO..1; bit 0 is never a priority.
  localparam logic [MASK_W-1:0] PRIO_BITS =
    ((MASK_W'(1) << (MAX_PRIO + 1)) - MASK_W'(1)) & ~MASK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [MASK_W-1:0] mask [3];
  logic [1:0]        k;
  logic              line_empty;

  logic [MASK_W-1:0] common_c;
  logic [5:0]        low_idx_c;
  logic              addr_last_c;

  // Items present in all three lines of the group, limited to legal priorities.
  assign common_c    = mask[0] & mask[1] & mask[2] & PRIO_BITS;
  assign addr_last_c = (rom_addr == {ADDR_W{1'b1}});

  // Lowest set bit of the common mask; scanning downward keeps the smallest.
  always_comb begin
    low_idx_c = 6'd0;
    for (int i = MASK_W - 1; i >= 1; i--) begin
      if (common_c[i]) low_idx_c = 6'(i);
    end
  end

  // Sequencer: state, ROM address, line masks and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rom_addr    <= '0;
      mask[0]     <= '0;
      mask[1]     <= '0;
      mask[2]     <= '0;
      k           <= 2'd0;
      line_empty  <= 1'b1;
      sum         <= 32'd0;
      group_count <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_READ;
            rom_addr    <= '0;
            mask[0]     <= '0;
            mask[1]     <= '0;
            mask[2]     <= '0;
            k           <= 2'd0;
            line_empty  <= 1'b1;
            sum         <= 32'd0;
            group_count <= 16'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
          end
        end

        ST_READ: begin
          if (rom_data == 8'd0 && line_empty) begin
            // End of data; an unfinished group is a fault and is dropped.
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            mask[0] <= '0;
            mask[1] <= '0;
            mask[2] <= '0;
            k       <= 2'd0;
            if (k != 2'd0) error <= 1'b1;
          end else if (addr_last_c) begin
            // Running off the top of the ROM ends the run rather than wrapping.
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            error   <= 1'b1;
            mask[0] <= '0;
            mask[1] <= '0;
            mask[2] <= '0;
            k       <= 2'd0;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
            if (rom_data == 8'd0) begin
              line_empty <= 1'b1;
              if (k == 2'd2) state <= ST_EVAL;
              else           k     <= k + 2'd1;
            end else begin
              line_empty <= 1'b0;
              if (rom_data <= MAX_BYTE) mask[k][rom_data[5:0]] <= 1'b1;
              else                      error                  <= 1'b1;
            end
          end
        end

        ST_EVAL: begin
          if (common_c == '0) error <= 1'b1;
          else                sum   <= sum + 32'(low_idx_c);
          if (group_count != 16'hFFFF) group_count <= group_count + 16'd1;
          mask[0] <= '0;
          mask[1] <= '0;
          mask[2] <= '0;
          k       <= 2'd0;
          state   <= ST_READ;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_day3_group_sequencer.sv
// Self-checking bench: a byte-array ROM model feeds the sequencer; expected
// run results are queued at start and compared when done rises.
module tb_day3_group_sequencer;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned ROM_SIZE = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [31:0]       sum;
  logic [15:0]       group_count;
  logic              busy;
  logic              done;
  logic              error;

  logic [7:0] rom_mem [ROM_SIZE];
  logic [7:0] img [$];

  typedef struct {
    logic [31:0] sum;
    logic [15:0] gc;
    logic        err;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  day3_group_sequencer #(.ADDR_W(ADDR_W), .MAX_PRIO(52)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sum         (sum),
    .group_count (group_count),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  function automatic int prio(input logic [7:0] ch);
    if (ch >= "a" && ch <= "z") return int'(ch) - int'("a") + 1;
    return int'(ch) - int'("A") + 27;
  endfunction

  task automatic add_line(input string s);
    for (int i = 0; i < s.len(); i++) img.push_back(8'(prio(s[i])));
    img.push_back(8'd0);
  endtask

  task automatic load_rom();
    for (int i = 0; i < int'(ROM_SIZE); i++)
      rom_mem[i] = (i < img.size()) ? img[i] : 8'h00;
  endtask

  task automatic load_basic();
    img = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd3, 8'd4, 8'd0, 8'd5, 8'd3, 8'd0, 8'd0};
    load_rom();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit timed_out);
    cyc = 0;
    while (!done && cyc < 20000) begin
      tick();
      cyc++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({rom_addr, sum, group_count, busy, done, error} !== '0)
      $display("FAIL reset_state got addr=%0d sum=%0d gc=%0d busy=%b done=%b err=%b exp all 0",
               rom_addr, sum, group_count, busy, done, error);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc; bit to; exp_t e;
    load_basic();
    sb.push_back('{32'd3, 16'd1, 1'b0});
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL basic_busy got busy=%b done=%b exp busy=1 done=0", busy, done);
    else n_pass++;
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || cyc != 12) $display("FAIL basic_latency got %0d cycles (timeout=%0b) exp 12", cyc, to);
    else n_pass++;
    n_checks++;
    if (sum !== e.sum) $display("FAIL basic_sum got %0d exp %0d", sum, e.sum);
    else n_pass++;
    n_checks++;
    if (group_count !== e.gc || error !== e.err || busy !== 1'b0)
      $display("FAIL basic_flags got gc=%0d err=%b busy=%b exp gc=%0d err=%b busy=0",
               group_count, error, busy, e.gc, e.err);
    else n_pass++;
    // Results must hold in DONE while start stays low.
    repeat (3) tick();
    n_checks++;
    if (sum !== e.sum || done !== 1'b1) $display("FAIL basic_hold got sum=%0d done=%b exp %0d done=1", sum, done, e.sum);
    else n_pass++;
  endtask

  task automatic test_two_groups();
    int cyc; bit to; exp_t e;
    img.delete();
    add_line("vJrwpWtwJgWrhcsFMMfFFhFp");
    add_line("jqHRNqRjqzjGDLGLrsFMfFZSrLrFZsSL");
    add_line("PmmdzqPrVvPwwTWBwg");
    add_line("wMqvLMZHhHMvwLHjbvcjnnSBnvTQFn");
    add_line("ttgJtRGJQctTZtZT");
    add_line("CrZsJsPPZsGzwwsLwLmpwMDw");
    img.push_back(8'd0);
    load_rom();
    sb.push_back('{32'd70, 16'd2, 1'b0});
    pulse_start();
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || sum !== e.sum) $display("FAIL two_groups_sum got %0d (timeout=%0b) exp %0d", sum, to, e.sum);
    else n_pass++;
    n_checks++;
    if (group_count !== e.gc || error !== e.err)
      $display("FAIL two_groups_flags got gc=%0d err=%b exp gc=%0d err=%b", group_count, error, e.gc, e.err);
    else n_pass++;
  endtask

  task automatic test_partial();
    int cyc; bit to; exp_t e;
    img = '{8'd7, 8'd0, 8'd7, 8'd0, 8'd0};
    load_rom();
    sb.push_back('{32'd0, 16'd0, 1'b1});
    pulse_start();
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || sum !== e.sum || group_count !== e.gc || error !== e.err)
      $display("FAIL partial got sum=%0d gc=%0d err=%b timeout=%0b exp sum=%0d gc=%0d err=%b",
               sum, group_count, error, to, e.sum, e.gc, e.err);
    else n_pass++;
  endtask

  task automatic test_bad_byte();
    int cyc; bit to; exp_t e;
    img = '{8'd60, 8'd1, 8'd0, 8'd2, 8'd0, 8'd3, 8'd0, 8'd0};
    load_rom();
    sb.push_back('{32'd0, 16'd1, 1'b1});
    pulse_start();
    // The out-of-range byte is the first one read; the flag appears right after.
    tick();
    n_checks++;
    if (error !== 1'b1) $display("FAIL bad_byte_early got err=%b exp 1", error);
    else n_pass++;
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || sum !== e.sum || group_count !== e.gc || error !== e.err)
      $display("FAIL bad_byte got sum=%0d gc=%0d err=%b timeout=%0b exp sum=%0d gc=%0d err=%b",
               sum, group_count, error, to, e.sum, e.gc, e.err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit to; exp_t e; int guard;
    load_basic();
    sb.push_back('{32'd3, 16'd1, 1'b0});
    pulse_start();
    guard = 0;
    while (rom_addr != ADDR_W'(5) && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (rom_addr != ADDR_W'(5)) $display("FAIL mid_reset_reach got addr=%0d exp 5", rom_addr);
    else n_pass++;
    rst = 1'b1;
    tick();
    sb.delete();
    n_checks++;
    if ({rom_addr, sum, group_count, busy, done, error} !== '0)
      $display("FAIL mid_reset_state got addr=%0d sum=%0d gc=%0d busy=%b done=%b err=%b exp all 0",
               rom_addr, sum, group_count, busy, done, error);
    else n_pass++;
    rst = 1'b0;
    tick();
    sb.push_back('{32'd3, 16'd1, 1'b0});
    pulse_start();
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || sum !== e.sum || group_count !== e.gc || error !== e.err)
      $display("FAIL mid_reset_rerun got sum=%0d gc=%0d err=%b timeout=%0b exp sum=%0d gc=%0d err=%b",
               sum, group_count, error, to, e.sum, e.gc, e.err);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int cyc; bit to; exp_t e;
    load_basic();
    sb.push_back('{32'd3, 16'd1, 1'b0});
    pulse_start();
    tick();
    tick();
    pulse_start();
    n_checks++;
    if (rom_addr !== ADDR_W'(3) || busy !== 1'b1)
      $display("FAIL busy_start_ignored got addr=%0d busy=%b exp addr=3 busy=1", rom_addr, busy);
    else n_pass++;
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || cyc != 9 || sum !== e.sum || group_count !== e.gc || error !== e.err)
      $display("FAIL busy_start_result got sum=%0d gc=%0d err=%b remaining=%0d exp sum=%0d gc=%0d err=%b remaining=9",
               sum, group_count, error, cyc, e.sum, e.gc, e.err);
    else n_pass++;
    // A start from DONE launches a clean second run.
    sb.push_back('{32'd3, 16'd1, 1'b0});
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || sum !== 32'd0)
      $display("FAIL done_restart_clear got done=%b busy=%b sum=%0d exp done=0 busy=1 sum=0", done, busy, sum);
    else n_pass++;
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || cyc != 12 || sum !== e.sum || group_count !== e.gc || error !== e.err)
      $display("FAIL done_restart_result got sum=%0d gc=%0d err=%b cycles=%0d exp sum=%0d gc=%0d err=%b cycles=12",
               sum, group_count, error, cyc, e.sum, e.gc, e.err);
    else n_pass++;
  endtask

  task automatic test_addr_boundary();
    int cyc; bit to; exp_t e;
    for (int i = 0; i < int'(ROM_SIZE); i++) rom_mem[i] = 8'd1;
    sb.push_back('{32'd0, 16'd0, 1'b1});
    pulse_start();
    wait_done(cyc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || rom_addr !== {ADDR_W{1'b1}} || cyc != int'(ROM_SIZE))
      $display("FAIL boundary_addr got addr=%0d cycles=%0d timeout=%0b exp addr=%0d cycles=%0d",
               rom_addr, cyc, to, ROM_SIZE - 1, ROM_SIZE);
    else n_pass++;
    n_checks++;
    if (sum !== e.sum || group_count !== e.gc || error !== e.err || busy !== 1'b0)
      $display("FAIL boundary_flags got sum=%0d gc=%0d err=%b busy=%b exp sum=%0d gc=%0d err=%b busy=0",
               sum, group_count, error, busy, e.sum, e.gc, e.err);
    else n_pass++;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    img.delete();
    load_rom();
    test_reset();
    test_basic();
    test_two_groups();
    test_partial();
    test_bad_byte();
    test_reset_mid_run();
    test_start_while_busy();
    test_addr_boundary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/day3_group_sequencer.md
DAY3_GROUP_SEQUENCER -- requirements
Module: day3_group_sequencer

Interface
REQ-001 Parameter ADDR_W, default 14: ROM address width.
REQ-002 Parameter MAX_PRIO, default 52: highest legal item priority.
REQ-003 The clock port SHALL be `clk  input  1`, the single clock; all state SHALL change on its rising edge.
REQ-004 The reset port SHALL be `rst  input  1`: synchronous, active-high reset.
REQ-005 `start  input  1` SHALL request a run; it is sampled only in IDLE or DONE.
REQ-006 `rom_addr  output  ADDR_W` SHALL be the registered read address to the external dist-mem ROM.
REQ-007 `rom_data  input  8` SHALL be the combinational ROM output for the current rom_addr, valid in the same cycle.
REQ-008 `sum  output  32` SHALL be the running priority total.
REQ-009 `group_count  output  16` SHALL count groups evaluated.
REQ-010 `busy  output  1` SHALL be high from the cycle after an accepted start until DONE is entered.
REQ-011 `done  output  1` SHALL be high while in DONE.
REQ-012 `error  output  1` SHALL be a sticky fault flag for the current run.

Function
REQ-013 ROM format SHALL be: byte 1..MAX_PRIO = item priority; 0x00 = end of line; 0x00 on an empty line = end of data.
REQ-014 States SHALL be IDLE, READ, EVAL and DONE.
REQ-015 IDLE/DONE + start: the block SHALL set rom_addr=0, clear the three 64-bit masks, sum, group_count, error and line index k (0..2), set line_empty=1 and busy=1, drop done, and go to READ.
REQ-016 READ, non-zero byte <= MAX_PRIO: the block SHALL set mask[k][rom_data], clear line_empty and increment rom_addr; one byte per cycle.
REQ-017 READ, byte > MAX_PRIO: the byte SHALL NOT be recorded; error SHALL be set, line_empty cleared and rom_addr incremented.
REQ-018 READ, 0x00 with line_empty=0: the block SHALL increment rom_addr and set line_empty=1; if k<2 it SHALL set k=k+1, else go to EVAL.
REQ-019 READ, 0x00 with line_empty=1: the block SHALL go to DONE; if k!=0 (partial group), it SHALL set error and discard the partial masks without adding to sum.
REQ-020 EVAL (exactly one cycle): with c = mask0 & mask1 & mask2, the block SHALL add p = lowest set bit index of c[MAX_PRIO:1] to sum.
REQ-021 EVAL: group_count SHALL increment whether or not c is zero.
REQ-022 EVAL: if c==0, sum SHALL be unchanged and error SHALL be set.
REQ-023 EVAL: the block SHALL clear the masks, set k=0, and return to READ; rom_addr SHALL NOT change in EVAL.
REQ-024 Group latency SHALL be total bytes of the three lines (including terminators) + 1 cycles.
REQ-025 Address boundary: if rom_addr = 2^ADDR_W-1 and would increment, the block SHALL set error and go to DONE with no wrap.
REQ-026 sum SHALL wrap modulo 2^32; group_count SHALL saturate at 0xFFFF.
REQ-027 DONE: done=1 and busy=0; sum, group_count and error SHALL hold until the next accepted start.
REQ-028 start in READ or EVAL SHALL be ignored.
REQ-029 sum, group_count and error outputs SHALL be registered and reflect updates the cycle after the causing edge.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, rom_addr=0, masks=0, k=0, line_empty=1, sum=0, group_count=0, busy=0, done=0, error=0.
REQ-031 rst SHALL override start and any in-flight operation, including a mid-line or mid-EVAL reset; no partial sum SHALL survive.
REQ-032 All outputs SHALL be defined from the first clock after rst; no reliance on initial values.

Verification
REQ-033 Basic: ROM {1,2,3,0, 3,4,0, 5,3,0, 0}, start pulse -> sum=3, group_count=1, error=0, done after 11+1 cycles of READ/EVAL.
REQ-034 Two groups (AoC sample priorities): groups with commons 18 then 52 -> sum=70, group_count=2, error=0.
REQ-035 Partial group: ROM {7,0, 7,0, 0} -> DONE, sum=0, group_count=0, error=1.
REQ-036 Bad byte / no common: ROM {60,1,0, 2,0, 3,0, 0} -> sum=0, group_count=1, error=1.
REQ-037 Reset mid-run: assert rst during the second line of the REQ-033 ROM -> next cycle IDLE, all outputs 0; restart -> sum=3.
REQ-038 Start while busy: pulse start during READ -> no restart, final result identical to REQ-033; start in DONE -> clean second run with identical result.
